// File: rtl/wait_state_memory.sv
// rtl/wait_state_memory.sv - wait-state RAM with ROM window and address mirroring; WAIT_STATE_MEMORY_STATS_EN adds access counters
module wait_state_memory #(
  parameter int          ADDR_WIDTH  = 16,
  parameter int          DATA_WIDTH  = 8,
  parameter int          DEPTH_LOG2  = 10,
  parameter int          WAIT_STATES = 0,
  parameter logic [15:0] ROM_BASE    = 16'h0300,
  parameter logic [15:0] ROM_TOP     = 16'h03FF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Req,
  input  logic                  WE,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [DATA_WIDTH-1:0] DataIn,
  output logic [DATA_WIDTH-1:0] DataOut,
  output logic                  Ready,
  output logic                  Busy,
  output logic                  Fault
`ifdef WAIT_STATE_MEMORY_STATS_EN
  ,
  output logic [15:0]           ReadCount,
  output logic [15:0]           WriteCount
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   mem [0:DEPTH-1];
  logic                    wr_q;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic [DATA_WIDTH-1:0]   din_q;
  logic [3:0]              cnt;

  logic [DEPTH_LOG2-1:0]   acc_idx;
  logic                    acc_we;
  logic                    acc_fault;
  logic                    unused_addr_bits;

  // Upper address bits only alias; they never select storage.
  assign unused_addr_bits = ^Address[ADDR_WIDTH-1:DEPTH_LOG2];

  // Index/type of the access about to enter DONE: live inputs when coming straight from IDLE.
  always_comb begin
    acc_idx   = idx_q;
    acc_we    = wr_q;
    if (state == S_IDLE) begin
      acc_idx = Address[DEPTH_LOG2-1:0];
      acc_we  = WE;
    end
    acc_fault = acc_we && (32'(acc_idx) >= 32'(ROM_BASE)) && (32'(acc_idx) <= 32'(ROM_TOP));
  end

  // Request capture, wait-state countdown and registered Ready/Fault/DataOut.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_IDLE;
      DataOut <= '0;
      Ready   <= 1'b0;
      Busy    <= 1'b0;
      Fault   <= 1'b0;
      cnt     <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      din_q   <= '0;
    end else begin
      Ready <= 1'b0;
      Fault <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Req) begin
            wr_q  <= WE;
            idx_q <= Address[DEPTH_LOG2-1:0];
            din_q <= DataIn;
            cnt   <= 4'(WAIT_STATES);
            Busy  <= 1'b1;
            if (WAIT_STATES == 0) begin
              state   <= S_DONE;
              Ready   <= 1'b1;
              Fault   <= acc_fault;
              DataOut <= mem[acc_idx];
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state   <= S_DONE;
            Ready   <= 1'b1;
            Fault   <= acc_fault;
            DataOut <= mem[acc_idx];
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          Busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Writes commit at the close of DONE so a reset in that cycle drops them.
  always_ff @(posedge CLK) begin
    if (!RST && state == S_DONE && wr_q && !Fault) begin
      mem[idx_q] <= din_q;
    end
  end

`ifdef WAIT_STATE_MEMORY_STATS_EN
  // Saturating counters of completed reads and committed writes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ReadCount  <= '0;
      WriteCount <= '0;
    end else if (state == S_DONE) begin
      if (!wr_q && ReadCount != 16'hFFFF) begin
        ReadCount <= ReadCount + 16'd1;
      end
      if (wr_q && !Fault && WriteCount != 16'hFFFF) begin
        WriteCount <= WriteCount + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_wait_state_memory.sv
// tb/tb_wait_state_memory.sv - directed and random checks of wait_state_memory against a reference model
module tb_wait_state_memory;

  localparam int WS0    = 0;
  localparam int WS3    = 3;
  localparam int ROM_LO = 'h300;
  localparam int ROM_HI = 'h3FF;

  logic        clk;
  logic        rst  [2];
  logic        req  [2];
  logic        we   [2];
  logic [15:0] addr [2];
  logic [7:0]  din  [2];
  logic [7:0]  dout [2];
  logic        rdy  [2];
  logic        bsy  [2];
  logic        flt  [2];
`ifdef WAIT_STATE_MEMORY_STATS_EN
  logic [15:0] rc   [2];
  logic [15:0] wc   [2];
`endif

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  mem_m [2][1024];
  bit          known [2][1024];
  int          rcnt  [2];
  int          wcnt  [2];

  wait_state_memory #(.WAIT_STATES(WS0)) u_d0 (
    .CLK(clk), .RST(rst[0]), .Req(req[0]), .WE(we[0]), .Address(addr[0]), .DataIn(din[0]),
    .DataOut(dout[0]), .Ready(rdy[0]), .Busy(bsy[0]), .Fault(flt[0])
`ifdef WAIT_STATE_MEMORY_STATS_EN
    , .ReadCount(rc[0]), .WriteCount(wc[0])
`endif
  );

  wait_state_memory #(.WAIT_STATES(WS3)) u_d3 (
    .CLK(clk), .RST(rst[1]), .Req(req[1]), .WE(we[1]), .Address(addr[1]), .DataIn(din[1]),
    .DataOut(dout[1]), .Ready(rdy[1]), .Busy(bsy[1]), .Fault(flt[1])
`ifdef WAIT_STATE_MEMORY_STATS_EN
    , .ReadCount(rc[1]), .WriteCount(wc[1])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ws(input int d);
    return (d == 0) ? WS0 : WS3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_stats(input int d, input string tag);
    @(negedge clk);
`ifdef WAIT_STATE_MEMORY_STATS_EN
    chk({tag, " rdcnt"}, 32'(rc[d]), 32'(rcnt[d]));
    chk({tag, " wrcnt"}, 32'(wc[d]), 32'(wcnt[d]));
`endif
  endtask

  task automatic do_access(input int d, input logic w, input logic [15:0] a, input logic [7:0] v,
                           output int lat, output int busy_n, output logic [7:0] dv, output logic fv);
    @(negedge clk);
    req[d] = 1'b1; we[d] = w; addr[d] = a; din[d] = v;
    @(negedge clk);
    req[d] = 1'b0; we[d] = 1'($urandom); addr[d] = 16'($urandom); din[d] = 8'($urandom);
    lat = -1; busy_n = 0; dv = '0; fv = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (bsy[d]) busy_n++;
      if (rdy[d]) begin
        lat = c; dv = dout[d]; fv = flt[d];
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic xact(input int d, input logic w, input logic [15:0] a, input logic [7:0] v, input string tag);
    int idx, lat, bn;
    logic prot, fv;
    logic [7:0] dv;
    idx  = int'(a) % 1024;
    prot = w && idx >= ROM_LO && idx <= ROM_HI;
    do_access(d, w, a, v, lat, bn, dv, fv);
    chk({tag, " lat"}, 32'(lat), 32'(ws(d) + 1));
    chk({tag, " busy"}, 32'(bn), 32'(ws(d) + 1));
    chk({tag, " fault"}, 32'(fv), 32'(prot));
    if (!prot && known[d][idx]) chk({tag, " data"}, 32'(dv), 32'(mem_m[d][idx]));
    if (w && !prot) begin
      mem_m[d][idx] = v; known[d][idx] = 1'b1; wcnt[d]++;
    end
    if (!w) rcnt[d]++;
  endtask

  initial begin
    int pulses, first_pos, last_pos, gap_bad, nrdy, idx;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; din[d] = '0;
      rcnt[d] = 0; wcnt[d] = 0;
      for (int i = 0; i < 1024; i++) known[d][i] = 1'b0;
    end
    u_d0.mem[7]      = 8'hAA; mem_m[0][7]      = 8'hAA; known[0][7]      = 1'b1;
    u_d0.mem['h304]  = 8'hFF; mem_m[0]['h304]  = 8'hFF; known[0]['h304]  = 1'b1;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst ready", 32'(rdy[d]), 32'(0));
      chk("rst dout", 32'(dout[d]), 32'(0));
      chk("rst busy", 32'(bsy[d]), 32'(0));
      chk("rst fault", 32'(flt[d]), 32'(0));
    end
    rst[0] = 1'b0; rst[1] = 1'b0;
    check_stats(0, "rst0");
    check_stats(1, "rst3");

    xact(0, 1'b0, 16'h0007, 8'h00, "rd7");
    xact(1, 1'b1, 16'h0010, 8'h5A, "ws3 wr");
    xact(1, 1'b0, 16'h0010, 8'h00, "ws3 rd");
    xact(1, 1'b1, 16'h0010, 8'h5B, "ws3 rbw");
    xact(0, 1'b1, 16'hFC05, 8'h33, "mir wr");
    xact(0, 1'b0, 16'h0005, 8'h00, "mir rd");
    xact(0, 1'b1, 16'h0304, 8'h00, "rom wr");
    xact(0, 1'b0, 16'h0304, 8'h00, "rom rd");
    xact(0, 1'b1, 16'h02FF, 8'h12, "below rom");
    xact(0, 1'b0, 16'h02FF, 8'h00, "below rom rd");
    xact(0, 1'b1, 16'h03FF, 8'h34, "rom top");
    xact(0, 1'b1, 16'h0700, 8'h56, "rom base mir");

    // Continuous Req: accepted only from IDLE, so one Ready per WS+2 cycles.
    xact(1, 1'b1, 16'h0001, 8'h42, "b2b setup");
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 16'h0001; din[1] = 8'h00;
    pulses = 0; first_pos = -1; last_pos = -1; gap_bad = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (rdy[1]) begin
        pulses++;
        chk("b2b data", 32'(dout[1]), 32'(8'h42));
        if (first_pos < 0) first_pos = c;
        else if (c - last_pos != WS3 + 2) gap_bad++;
        last_pos = c;
      end
      if (c == 20) req[1] = 1'b0;
    end
    rcnt[1] += 4;
    chk("b2b pulses", 32'(pulses), 32'(4));
    chk("b2b first", 32'(first_pos), 32'(WS3 + 1));
    chk("b2b gaps", 32'(gap_bad), 32'(0));
    check_stats(1, "b2b");

    // Reset while a write is in WAIT must drop it entirely.
    xact(1, 1'b1, 16'h0020, 8'h11, "abort setup");
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 16'h0020; din[1] = 8'h77;
    @(negedge clk);
    req[1] = 1'b0;
    @(negedge clk);
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    rcnt[1] = 0; wcnt[1] = 0;
    chk("abort busy", 32'(bsy[1]), 32'(0));
    nrdy = 0;
    for (int c = 0; c < 8; c++) begin
      if (rdy[1]) nrdy++;
      @(negedge clk);
    end
    chk("abort ready", 32'(nrdy), 32'(0));
    check_stats(1, "abort");
    xact(1, 1'b0, 16'h0020, 8'h00, "abort rd");
    check_stats(1, "after abort");

    // Random traffic over a small index pool straddling the ROM base.
    for (int n = 0; n < 60; n++) begin
      int d;
      d   = n % 2;
      idx = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range('h2F0, 'h30F));
      xact(d, 1'($urandom), {6'($urandom), 10'(idx)}, 8'($urandom), "rand");
    end
    check_stats(0, "final0");
    check_stats(1, "final3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
